alu_execute_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 35 +++
 rtl/alu_mul_seq.sv | 64 ++++++
 rtl/alu_execute_stage.sv | 197 +++++++++++++++++++
 tb/tb_alu_execute_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared widths, flag bit positions and opcode encoding for the
//            execute stage and its multiply sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = 4;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        OP_MOV = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_ORR = 4'd4,
        OP_EOR = 4'd5,
        OP_LSL = 4'd6,
        OP_LSR = 4'd7,
        OP_CMP = 4'd8,
        OP_MUL = 4'd9
    } opcode_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ============================================================================
// Module   : alu_mul_seq
// Purpose  : Iterative 32-step shift-add multiplier returning the low 32 bits
//            of a*b; done is high during the final step, product valid then.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_seq
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic [4:0]        r_cnt;
    logic              r_busy;

    logic [DATA_W-1:0] w_addend;
    logic [DATA_W-1:0] w_acc_next;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;

    // The last partial product is folded in combinationally so the result
    // is available in the same cycle done is raised.
    assign done    = r_busy && (r_cnt == 5'd31);
    assign product = w_acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_execute_stage.sv
// ============================================================================
// Module   : alu_execute_stage
// Purpose  : Execute stage feeding the register-bank write port and NZCV flags.
//            Define ALU_MUL_EN to build the iterative MUL sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_execute_stage
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           opcode,
    input  logic [REG_IDX_W-1:0] dest_in,
    input  logic [DATA_W-1:0]    op_a,
    input  logic [DATA_W-1:0]    op_b,
    output logic                 wb_valid,
    output logic [REG_IDX_W-1:0] wb_dest,
    output logic [DATA_W-1:0]    wb_data,
    output logic [3:0]           flags,
    output logic                 err
);

`ifdef ALU_MUL_EN
    localparam logic c_MUL_EN = 1'b1;
`else
    localparam logic c_MUL_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_MUL_RUN = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                 r_wb_valid;
    logic [REG_IDX_W-1:0] r_wb_dest;
    logic [DATA_W-1:0]    r_wb_data;
    logic [3:0]           r_flags;
    logic                 r_err;
    logic [REG_IDX_W-1:0] r_mul_dest;

    opcode_t           w_op;
    logic              w_accept;
    logic              w_is_mul;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_mul_product;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [4:0]        w_shamt;
    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic              w_v;
    logic              w_wr;
    logic              w_illegal;
    logic [3:0]        w_flags_alu;

    assign w_op     = opcode_t'(opcode);
    assign w_accept = in_valid && in_ready;
    assign w_is_mul = c_MUL_EN && (w_op == OP_MUL);

`ifdef ALU_MUL_EN
    alu_mul_seq u_mul_seq (
        .clk     (clk),
        .rst     (rst),
        .start   (w_accept && w_is_mul),
        .a       (op_a),
        .b       (op_b),
        .done    (w_mul_done),
        .product (w_mul_product)
    );
    assign in_ready = (r_state == S_IDLE);
`else
    assign w_mul_done    = 1'b0;
    assign w_mul_product = '0;
    assign in_ready      = 1'b1;
`endif

    // Subtraction as a + ~b + 1 so bit 32 is the ARM-style "no borrow" carry
    assign w_sum   = {1'b0, op_a} + {1'b0, op_b};
    assign w_diff  = {1'b0, op_a} + {1'b0, ~op_b} + {{DATA_W{1'b0}}, 1'b1};
    assign w_shamt = op_b[4:0];

    always_comb begin
        w_res     = '0;
        w_c       = r_flags[FLAG_C];
        w_v       = r_flags[FLAG_V];
        w_wr      = 1'b1;
        w_illegal = 1'b0;
        case (w_op)
            OP_MOV: w_res = op_b;
            OP_ADD: begin
                w_res = w_sum[DATA_W-1:0];
                w_c   = w_sum[DATA_W];
                w_v   = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                        (w_sum[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_SUB, OP_CMP: begin
                w_res = w_diff[DATA_W-1:0];
                w_c   = w_diff[DATA_W];
                w_v   = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                        (w_diff[DATA_W-1] != op_a[DATA_W-1]);
                w_wr  = (w_op == OP_SUB);
            end
            OP_AND: w_res = op_a & op_b;
            OP_ORR: w_res = op_a | op_b;
            OP_EOR: w_res = op_a ^ op_b;
            // Index arithmetic wraps mod 32; only used when the shift is non-zero
            OP_LSL: begin
                w_res = op_a << w_shamt;
                if (w_shamt != 5'd0) begin
                    w_c = op_a[5'd0 - w_shamt];
                end
            end
            OP_LSR: begin
                w_res = op_a >> w_shamt;
                if (w_shamt != 5'd0) begin
                    w_c = op_a[w_shamt - 5'd1];
                end
            end
            OP_MUL: begin
                w_wr      = 1'b0;
                w_illegal = !c_MUL_EN;
            end
            default: begin
                w_wr      = 1'b0;
                w_illegal = 1'b1;
            end
        endcase
        w_flags_alu = {w_res[DATA_W-1], (w_res == '0), w_c, w_v};
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept && w_is_mul) w_state_next = S_MUL_RUN;
            S_MUL_RUN: if (w_mul_done)           w_state_next = S_IDLE;
            default:                             w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_dest  <= '0;
            r_wb_data  <= '0;
            r_flags    <= 4'd0;
            r_err      <= 1'b0;
            r_mul_dest <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            r_err      <= 1'b0;
            if ((r_state == S_MUL_RUN) && w_mul_done) begin
                r_wb_valid      <= 1'b1;
                r_wb_dest       <= r_mul_dest;
                r_wb_data       <= w_mul_product;
                r_flags[FLAG_N] <= w_mul_product[DATA_W-1];
                r_flags[FLAG_Z] <= (w_mul_product == '0);
            end else if (w_accept) begin
                if (w_is_mul) begin
                    r_mul_dest <= dest_in;
                end else if (w_illegal) begin
                    r_err <= 1'b1;
                end else begin
                    r_flags <= w_flags_alu;
                    if (w_wr) begin
                        r_wb_valid <= 1'b1;
                        r_wb_dest  <= dest_in;
                        r_wb_data  <= w_res;
                    end
                end
            end
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_dest  = r_wb_dest;
    assign wb_data  = r_wb_data;
    assign flags    = r_flags;
    assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_execute_stage.sv
// ============================================================================
// Module   : tb_alu_execute_stage
// Purpose  : Directed plus randomized checks of alu_execute_stage against a
//            cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_execute_stage;

`ifdef ALU_MUL_EN
    localparam bit c_MUL_EN = 1'b1;
`else
    localparam bit c_MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [3:0]  dest_in;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;
    logic [3:0]  flags;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    int          m_busy = 0;
    logic [31:0] m_mul_res;
    logic [3:0]  m_mul_dest;
    logic [3:0]  m_flags = 4'd0;

    alu_execute_stage dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .dest_in  (dest_in),
        .op_a     (op_a),
        .op_b     (op_b),
        .wb_valid (wb_valid),
        .wb_dest  (wb_dest),
        .wb_data  (wb_data),
        .flags    (flags),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] fin, output logic [31:0] r,
                                   output logic [3:0] fo, output bit wr, output bit ill);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          s;
        longint unsigned ua = a;
        longint unsigned ub = b;
        int              sh = int'(b[4:0]);
        bit              c  = fin[1];
        bit              v  = fin[0];
        r = 32'd0; wr = 1'b1; ill = 1'b0;
        case (op)
            4'd0: r = b;
            4'd1: begin
                r = a + b;
                c = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2, 4'd8: begin
                r  = a - b;
                c  = (a >= b);
                s  = sa - sb;
                v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                wr = (op == 4'd2);
            end
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: begin r = a << sh; if (sh != 0) c = a[32 - sh]; end
            4'd7: begin r = a >> sh; if (sh != 0) c = a[sh - 1]; end
            default: begin ill = 1'b1; wr = 1'b0; end
        endcase
        fo = ill ? fin : {r[31], (r == 32'd0), c, v};
    endfunction

    // One clock: predict from the inputs present at the edge, then compare
    task automatic cycle(output bit accepted);
        bit          acc, wr, ill, exp_valid, exp_err;
        logic [31:0] r, exp_data;
        logic [3:0]  f, exp_dest;
        longint unsigned p;
        acc = in_valid && (m_busy == 0) && !rst;
        exp_valid = 1'b0; exp_err = 1'b0; exp_data = 32'd0; exp_dest = 4'd0;
        if (rst) begin
            m_busy = 0; m_flags = 4'd0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                exp_valid = 1'b1; exp_data = m_mul_res; exp_dest = m_mul_dest;
                m_flags = {m_mul_res[31], (m_mul_res == 32'd0), m_flags[1:0]};
            end
        end else if (acc) begin
            if (opcode == 4'd9 && c_MUL_EN) begin
                p = longint'(op_a) * longint'(op_b);
                m_mul_res = p[31:0]; m_mul_dest = dest_in; m_busy = 32;
            end else begin
                ref_op(opcode, op_a, op_b, m_flags, r, f, wr, ill);
                m_flags = f; exp_err = ill;
                if (wr) begin exp_valid = 1'b1; exp_data = r; exp_dest = dest_in; end
            end
        end
        @(posedge clk);
        #1;
        check("in_ready", in_ready, (m_busy == 0));
        check("wb_valid", wb_valid, exp_valid);
        check("err", err, exp_err);
        check("flags", flags, m_flags);
        if (exp_valid || rst) begin
            check("wb_data", wb_data, exp_data);
            check("wb_dest", wb_dest, exp_dest);
        end
        accepted = acc;
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] d, input logic [31:0] a,
                        input logic [31:0] b, output int n);
        bit acc = 1'b0;
        n = 0;
        in_valid = 1'b1; opcode = op; dest_in = d; op_a = a; op_b = b;
        while (!acc && n < 100) begin
            cycle(acc);
            n++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc, hold;
        int n, wb_at;
        rst = 1'b1; in_valid = 1'b0; opcode = 4'd0; dest_in = 4'd0; op_a = 32'd0; op_b = 32'd0;
        cycle(acc);
        cycle(acc);
        check("rst_ready", in_ready, 1);
        check("rst_flags", flags, 4'd0);
        rst = 1'b0;

        send(4'd1, 4'd3, 32'hFFFF_FFFF, 32'd1, n);
        check("add_data", wb_data, 32'd0);
        check("add_dest", wb_dest, 4'd3);
        check("add_flags", flags, 4'b0110);

        send(4'd2, 4'd1, 32'd5, 32'd7, n);
        check("sub_data", wb_data, 32'hFFFF_FFFE);
        check("sub_flags", flags, 4'b1000);
        send(4'd1, 4'd2, 32'h7FFF_FFFF, 32'd1, n);
        check("b2b_accept", n, 1);
        check("ovf_data", wb_data, 32'h8000_0000);
        check("ovf_flags", flags, 4'b1001);

        send(4'd8, 4'd4, 32'd3, 32'd3, n);
        check("cmp_wb", wb_valid, 0);
        check("cmp_flags", flags, 4'b0110);
        send(4'd6, 4'd5, 32'h8000_0001, 32'd1, n);
        check("lsl_data", wb_data, 32'h0000_0002);
        check("lsl_flags", flags, 4'b0010);
        send(4'd7, 4'd6, 32'd2, 32'h20, n);
        check("lsr0_flags", flags, 4'b0010);

        send(4'hF, 4'd7, 32'd1, 32'd1, n);
        check("ill_err", err, 1);
        check("ill_wb", wb_valid, 0);
        check("ill_flags", flags, 4'b0010);
        cycle(acc);
        check("ill_err_pulse", err, 0);

`ifdef ALU_MUL_EN
        send(4'd9, 4'd8, 32'd1234, 32'd5678, n);
        check("mul_ready_low", in_ready, 0);
        in_valid = 1'b1; opcode = 4'd1; dest_in = 4'd9; op_a = 32'd10; op_b = 32'd20;
        n = 0; wb_at = 0; acc = 1'b0;
        while (!acc && n < 40) begin
            cycle(acc);
            n++;
            if (wb_valid) begin
                wb_at = n;
                check("mul_data", wb_data, 32'h006A_E9BC);
            end
        end
        in_valid = 1'b0;
        check("mul_wb_cycle", wb_at, 32);
        check("mul_next_accept", n, 33);
`else
        send(4'd9, 4'd8, 32'd1234, 32'd5678, n);
        check("mul_off_err", err, 1);
        check("mul_off_ready", in_ready, 1);
`endif

        send(4'd9, 4'd8, 32'd3, 32'd4, n);
        for (int i = 0; i < 10; i++) cycle(acc);
        rst = 1'b1;
        cycle(acc);
        rst = 1'b0;
        check("abort_flags", flags, 4'd0);
        check("abort_ready", in_ready, 1);
        for (int i = 0; i < 40; i++) cycle(acc);

        hold = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                opcode   = 4'($urandom_range(0, 15));
                dest_in  = 4'($urandom_range(0, 15));
                op_a     = pick();
                op_b     = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : pick();
            end
            cycle(acc);
            hold = in_valid && !acc;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) cycle(acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
